// File: rtl/hazard_ctrl_if.sv
// Hazard scheduler signal bundle.
//   slave  : hazard_ctrl side (pipeline status in, HZ_* controls out)
//   master : pipeline / bench side (drives status, observes controls)
interface hazard_ctrl_if;
  logic [4:0] ID_rs1, ID_rs2;
  logic       ID_rs1_vld, ID_rs2_vld;
  logic [4:0] EX_rd;
  logic       EX_rd_vld, EX_is_load, EX_mdu_start, EX_br_taken;
  logic       MDU_done, MEM_req, MEM_ack;
  logic       HZ_pc_stall, HZ_id_stall, HZ_ex_bubble, HZ_flush, HZ_bus_err;
  logic [1:0] HZ_state;

  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_vld, ID_rs2_vld, EX_rd, EX_rd_vld,
           EX_is_load, EX_mdu_start, EX_br_taken, MDU_done, MEM_req, MEM_ack,
    output HZ_pc_stall, HZ_id_stall, HZ_ex_bubble, HZ_flush, HZ_bus_err,
           HZ_state
  );

  modport master (
    output ID_rs1, ID_rs2, ID_rs1_vld, ID_rs2_vld, EX_rd, EX_rd_vld,
           EX_is_load, EX_mdu_start, EX_br_taken, MDU_done, MEM_req, MEM_ack,
    input  HZ_pc_stall, HZ_id_stall, HZ_ex_bubble, HZ_flush, HZ_bus_err,
           HZ_state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32 pipeline hazard scheduler (load-use, multi-cycle MDU,
// data-bus wait states with watchdog, taken-branch flush).
// Ports:
//   clk, rst   core clock, asynchronous active-high reset
//   hz         hazard_ctrl_if.slave: pipeline status in, HZ_* controls out
//   HZ_stall_cnt, HZ_flush_cnt  (only with HZ_PERF_CNT_EN defined)
//              saturating counts of pc-stall / flush cycles
// Stall/bubble/flush are combinational; HZ_bus_err and HZ_state registered.
// Optional feature macro: HZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
`ifdef HZ_PERF_CNT_EN
  ,
  output logic [31:0]   HZ_stall_cnt,
  output logic [31:0]   HZ_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    MEM_WAIT = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_PRE  = CNT_W'(MEM_TIMEOUT - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             load_use;
  logic             stall, bubble, flush;

  assign load_use = hz.EX_is_load & hz.EX_rd_vld & (hz.EX_rd != 5'd0) &
                    ((hz.ID_rs1_vld & (hz.ID_rs1 == hz.EX_rd)) |
                     (hz.ID_rs2_vld & (hz.ID_rs2 == hz.EX_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        cnt_d = '0;
        // A taken branch squashes the ID instruction, so its load-use is moot.
        if (hz.EX_br_taken) flush = 1'b1;
        else if (load_use) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
        if (hz.MEM_req & ~hz.MEM_ack)                state_d = MEM_WAIT;
        else if (hz.EX_mdu_start & ~hz.MDU_done)     state_d = MDU_WAIT;
      end
      MDU_WAIT: begin
        stall = 1'b1;
        if (hz.MDU_done) state_d = RUN;
      end
      MEM_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // Error pulse is raised one cycle early so the registered flag lands
        // on the final wait cycle; any ack in that final cycle is ignored.
        if (cnt_q == TO_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (hz.MEM_ack) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == TO_PRE) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Gate the combinational controls so everything reads 0 while in reset.
  assign hz.HZ_pc_stall  = stall  & ~rst;
  assign hz.HZ_id_stall  = stall  & ~rst;
  assign hz.HZ_ex_bubble = bubble & ~rst;
  assign hz.HZ_flush     = flush  & ~rst;
  assign hz.HZ_bus_err   = err_q;
  assign hz.HZ_state     = state_q;

`ifdef HZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      HZ_stall_cnt <= '0;
      HZ_flush_cnt <= '0;
    end else begin
      if (hz.HZ_pc_stall && HZ_stall_cnt != 32'hFFFF_FFFF)
        HZ_stall_cnt <= HZ_stall_cnt + 32'd1;
      if (hz.HZ_flush && HZ_flush_cnt != 32'hFFFF_FFFF)
        HZ_flush_cnt <= HZ_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
